// File: rtl/bb_arb_pkg.sv
// Shared types and helpers for the bb resource arbiter and its round-robin picker.
package bb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_e;

    localparam int N_DEFAULT = 4;
    localparam int W_DEFAULT = 8;

    // Pointer width for N requesters; never narrower than one bit.
    function automatic int ptr_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int PTR_W = ptr_w(N_DEFAULT);

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted req at or after ptr, wrapping mod N.
module rr_pick
    import bb_arb_pkg::*;
#(
    parameter  int N  = N_DEFAULT,
    localparam int PW = ptr_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic          any,
    output logic [PW-1:0] idx
);

    always_comb begin
        any = |req;
        idx = '0;
        // Scan from the far end so the candidate closest to ptr is written last.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[(int'(ptr) + i) % N]) begin
                idx = PW'((int'(ptr) + i) % N);
            end
        end
    end

endmodule

// File: rtl/bb_share_arbiter.sv
// Round-robin sharing of one registered AND unit (bb) between N requesters,
// sequencing issue, wait and a one-cycle ack per operation.
module bb_share_arbiter
    import bb_arb_pkg::*;
#(
    parameter int N = N_DEFAULT,
    parameter int W = W_DEFAULT
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] op_a,
    input  logic [N*W-1:0] op_b,
    output logic [N-1:0]   ack,
    output logic [W-1:0]   rsp_data,
    output logic           busy,
    output logic [W-1:0]   bb_in1,
    output logic [W-1:0]   bb_in2,
    input  logic [W-1:0]   bb_out
);

    localparam int PW = ptr_w(N);

    arb_state_e    state_q, state_d;
    logic [PW-1:0] rr_ptr_q, rr_ptr_d;
    logic [PW-1:0] gnt_idx_q, gnt_idx_d;
    logic [W-1:0]  bb_in1_q, bb_in1_d;
    logic [W-1:0]  bb_in2_q, bb_in2_d;
    logic [W-1:0]  rsp_q, rsp_d;
    logic [N-1:0]  ack_q, ack_d;

    logic          pick_any;
    logic [PW-1:0] pick_idx;

    rr_pick #(.N(N)) u_pick (
        .req (req),
        .ptr (rr_ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            gnt_idx_q <= '0;
            bb_in1_q  <= '0;
            bb_in2_q  <= '0;
            rsp_q     <= '0;
            ack_q     <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            gnt_idx_q <= gnt_idx_d;
            bb_in1_q  <= bb_in1_d;
            bb_in2_q  <= bb_in2_d;
            rsp_q     <= rsp_d;
            ack_q     <= ack_d;
        end
    end

    // The bb operand registers double as the operand latch: loaded only on entry
    // to ISSUE and zero in every other state.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        gnt_idx_d = gnt_idx_q;
        bb_in1_d  = '0;
        bb_in2_d  = '0;
        rsp_d     = rsp_q;
        ack_d     = '0;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d   = ISSUE;
                    gnt_idx_d = pick_idx;
                    bb_in1_d  = op_a[int'(pick_idx)*W +: W];
                    bb_in2_d  = op_b[int'(pick_idx)*W +: W];
                    rr_ptr_d  = (pick_idx == PW'(N - 1)) ? '0 : pick_idx + PW'(1);
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                state_d          = DONE;
                rsp_d            = bb_out;
                ack_d[gnt_idx_q] = 1'b1;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ack      = ack_q;
    assign rsp_data = rsp_q;
    assign busy     = (state_q != IDLE);
    assign bb_in1   = bb_in1_q;
    assign bb_in2   = bb_in2_q;

endmodule
